// File: rtl/lock_key_loader_if.sv
// Serial key-bit handshake between a key source (master) and the loader (slave).
interface lock_key_loader_if;
  logic key_bit;
  logic key_valid;
  logic key_ready;

  modport master (output key_bit, output key_valid, input key_ready);
  modport slave  (input key_bit, input key_valid, output key_ready);
endinterface

// File: rtl/lock_key_loader.sv
// Serial key-load controller for the locked c432 netlists: parity-checked
// frame capture, decoy key until accepted, lockout after repeated bad frames.
module lock_key_loader #(
  parameter int unsigned           KEY_W     = 9,
  parameter int unsigned           MAX_TRIES = 3,
  parameter int unsigned           CNT_W     = 2,
  parameter logic [KEY_W-1:0]      DECOY     = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  lock_key_loader_if.slave     kif,
  output logic [KEY_W-1:0]     key_out,
  output logic                 key_ok,
  output logic                 busy,
  output logic                 err,
  output logic                 locked_out,
  output logic [CNT_W-1:0]     fail_cnt
);

  localparam int unsigned BW = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_ACTIVE, S_ERROR, S_LOCKOUT
  } state_t;

  state_t             state, state_n;
  logic [BW-1:0]      cnt, cnt_n;
  logic [KEY_W-1:0]   shift, shift_n;
  logic               par, par_n;
  logic [KEY_W-1:0]   key_out_n;
  logic               key_ok_n, err_n, locked_out_n;
  logic [CNT_W-1:0]   fail_cnt_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shift      <= '0;
      par        <= 1'b0;
      key_out    <= DECOY;
      key_ok     <= 1'b0;
      err        <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      key_out    <= key_out_n;
      key_ok     <= key_ok_n;
      err        <= err_n;
      locked_out <= locked_out_n;
      fail_cnt   <= fail_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    shift_n       = shift;
    par_n         = par;
    key_out_n     = key_out;
    key_ok_n      = key_ok;
    err_n         = err;
    locked_out_n  = locked_out;
    fail_cnt_n    = fail_cnt;
    kif.key_ready = 1'b0;
    busy          = 1'b0;

    case (state)
      S_IDLE, S_ACTIVE, S_ERROR: begin
        if (start) begin
          state_n   = S_LOAD;
          key_out_n = DECOY;
          key_ok_n  = 1'b0;
          err_n     = 1'b0;
          cnt_n     = '0;
          shift_n   = '0;
          par_n     = 1'b0;
        end
      end

      S_LOAD: begin
        kif.key_ready = 1'b1;
        busy          = 1'b1;
        // restart wins over a coincident transfer, whose bit is dropped
        if (start) begin
          cnt_n   = '0;
          shift_n = '0;
          par_n   = 1'b0;
        end else if (kif.key_valid) begin
          par_n = par ^ kif.key_bit;
          if (cnt == BW'(KEY_W)) begin
            state_n = S_CHECK;
          end else begin
            shift_n[cnt] = kif.key_bit;
            cnt_n        = cnt + BW'(1);
          end
        end
      end

      S_CHECK: begin
        busy = 1'b1;
        // par holds the XOR of all key bits and the parity bit
        if (!par) begin
          state_n    = S_ACTIVE;
          key_out_n  = shift;
          key_ok_n   = 1'b1;
          err_n      = 1'b0;
          fail_cnt_n = '0;
        end else if (int'(fail_cnt) + 1 < int'(MAX_TRIES)) begin
          state_n    = S_ERROR;
          fail_cnt_n = fail_cnt + CNT_W'(1);
          err_n      = 1'b1;
        end else begin
          state_n      = S_LOCKOUT;
          fail_cnt_n   = CNT_W'(MAX_TRIES);
          err_n        = 1'b1;
          locked_out_n = 1'b1;
        end
      end

      S_LOCKOUT: ;

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed self-checking bench for lock_key_loader.
module tb_lock_key_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] key_out;
  logic       key_ok, busy, err, locked_out;
  logic [1:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  lock_key_loader_if kif ();

  lock_key_loader #(
    .KEY_W(9), .MAX_TRIES(3), .CNT_W(2), .DECOY(9'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kif(kif),
    .key_out(key_out), .key_ok(key_ok), .busy(busy), .err(err),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    for (int unsigned g = 0; g < gap; g++) begin
      kif.key_valid = 1'b0;
      kif.key_bit   = ~b;
      tick();
    end
    kif.key_valid = 1'b1;
    kif.key_bit   = b;
    tick();
    kif.key_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] key, input logic p, input int unsigned maxgap);
    for (int unsigned i = 0; i < 9; i++)
      send_bit(key[i], (maxgap == 0) ? 0 : i % (maxgap + 1));
    send_bit(p, 0);
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_ready", 32'(kif.key_ready), 32'd0);
    tick();
  endtask

  initial begin
    kif.key_valid = 1'b0;
    kif.key_bit   = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_key_out", 32'(key_out), 32'h000);
    chk("rst_key_ok", 32'(key_ok), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_locked", 32'(locked_out), 32'd0);
    chk("rst_ready", 32'(kif.key_ready), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: good frame
    pulse_start();
    chk("s1_ready", 32'(kif.key_ready), 32'd1);
    chk("s1_busy_load", 32'(busy), 32'd1);
    send_frame(9'h1A5, 1'b1, 0);
    chk("s1_key_out", 32'(key_out), 32'h1A5);
    chk("s1_key_ok", 32'(key_ok), 32'd1);
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("s1_busy", 32'(busy), 32'd0);

    // 2: bad then good
    pulse_start();
    send_frame(9'h0F0, 1'b1, 0);
    chk("s2_err", 32'(err), 32'd1);
    chk("s2_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("s2_key_out", 32'(key_out), 32'h000);
    chk("s2_key_ok", 32'(key_ok), 32'd0);
    pulse_start();
    chk("s2_err_clr", 32'(err), 32'd0);
    chk("s2_fail_kept", 32'(fail_cnt), 32'd1);
    send_frame(9'h0F0, 1'b0, 0);
    chk("s2_key_ok2", 32'(key_ok), 32'd1);
    chk("s2_fail_cnt2", 32'(fail_cnt), 32'd0);
    chk("s2_key_out2", 32'(key_out), 32'h0F0);

    // 3: lockout
    pulse_start();
    send_frame(9'h0F0, 1'b1, 0);
    chk("s3_fail1", 32'(fail_cnt), 32'd1);
    pulse_start();
    send_frame(9'h0F0, 1'b1, 0);
    chk("s3_fail2", 32'(fail_cnt), 32'd2);
    chk("s3_not_locked", 32'(locked_out), 32'd0);
    pulse_start();
    send_frame(9'h0F0, 1'b1, 0);
    chk("s3_fail3", 32'(fail_cnt), 32'd3);
    chk("s3_locked", 32'(locked_out), 32'd1);
    chk("s3_err", 32'(err), 32'd1);
    chk("s3_ready", 32'(kif.key_ready), 32'd0);
    start = 1'b1;
    kif.key_valid = 1'b1;
    kif.key_bit = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    kif.key_valid = 1'b0;
    chk("s3_still_locked", 32'(locked_out), 32'd1);
    chk("s3_still_fail", 32'(fail_cnt), 32'd3);
    chk("s3_still_ready", 32'(kif.key_ready), 32'd0);
    chk("s3_still_busy", 32'(busy), 32'd0);
    chk("s3_still_key", 32'(key_out), 32'h000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s3_rst_locked", 32'(locked_out), 32'd0);
    chk("s3_rst_fail", 32'(fail_cnt), 32'd0);
    chk("s3_rst_err", 32'(err), 32'd0);
    chk("s3_rst_busy", 32'(busy), 32'd0);

    // 4: good frame with gaps
    pulse_start();
    send_frame(9'h1A5, 1'b1, 4);
    chk("s4_key_out", 32'(key_out), 32'h1A5);
    chk("s4_key_ok", 32'(key_ok), 32'd1);
    chk("s4_err", 32'(err), 32'd0);
    chk("s4_fail_cnt", 32'(fail_cnt), 32'd0);

    // 5: restart mid-frame
    pulse_start();
    repeat (5) send_bit(1'b1, 0);
    start = 1'b1;
    kif.key_valid = 1'b1;
    kif.key_bit = 1'b1;
    tick();
    start = 1'b0;
    kif.key_valid = 1'b0;
    chk("s5_busy", 32'(busy), 32'd1);
    chk("s5_ready", 32'(kif.key_ready), 32'd1);
    send_frame(9'h155, 1'b1, 0);
    chk("s5_key_out", 32'(key_out), 32'h155);
    chk("s5_key_ok", 32'(key_ok), 32'd1);

    // 6: reload from ACTIVE, then reset mid-LOAD
    pulse_start();
    send_frame(9'h1A5, 1'b1, 0);
    chk("s6_key_out", 32'(key_out), 32'h1A5);
    pulse_start();
    chk("s6_key_ok_drop", 32'(key_ok), 32'd0);
    chk("s6_decoy", 32'(key_out), 32'h000);
    chk("s6_ready", 32'(kif.key_ready), 32'd1);
    repeat (3) send_bit(1'b1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s6_rst_ready", 32'(kif.key_ready), 32'd0);
    chk("s6_rst_key", 32'(key_out), 32'h000);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    pulse_start();
    send_frame(9'h0F0, 1'b0, 0);
    chk("s6_after_key", 32'(key_out), 32'h0F0);
    chk("s6_after_ok", 32'(key_ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
